// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 stream demultiplexer: each input word is steered by in_sel
// into one of four independent 2-entry FIFOs, so a stalled sink only blocks its own traffic.
module demux_1_4_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic             d1_valid,
   output logic             d2_valid,
   output logic             d3_valid,
   output logic             d4_valid,
   input  logic             d1_ready,
   input  logic             d2_ready,
   input  logic             d3_ready,
   input  logic             d4_ready,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] d3,
   output logic [WIDTH-1:0] d4,
   output logic             err_drop
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
   // valid never depends on ready; in_ready depends only on FIFO state and in_sel.

   logic [3:0]         full;
   logic [3:0]         empty;
   logic [3:0]         out_ready;
   logic [4*WIDTH-1:0] head;
   logic               stall_q;
   logic [1:0]         sel_q;

   assign out_ready = {d4_ready, d3_ready, d2_ready, d1_ready};
   assign in_ready  = ~full[in_sel];

   for (genvar g = 0; g < 4; g++) begin : g_ch
      logic [WIDTH-1:0] slot0;
      logic [WIDTH-1:0] slot1;
      logic             wr_ptr;
      logic             rd_ptr;
      logic [1:0]       count;
      logic             push;
      logic             pop;

      assign empty[g] = (count == 2'd0);
      assign full[g]  = (count == 2'(DEPTH));
      assign push     = in_valid & ~full[g] & (in_sel == 2'(g));
      assign pop      = ~empty[g] & out_ready[g];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (push) begin
               if (wr_ptr) slot1 <= in_data;
               else        slot0 <= in_data;
               wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end

      // Head comes straight from registered slots; forced to zero when the FIFO is empty.
      assign head[g*WIDTH +: WIDTH] = empty[g] ? '0 : (rd_ptr ? slot1 : slot0);
   end

   assign d1_valid = ~empty[0];
   assign d2_valid = ~empty[1];
   assign d3_valid = ~empty[2];
   assign d4_valid = ~empty[3];
   assign d1 = head[0*WIDTH +: WIDTH];
   assign d2 = head[1*WIDTH +: WIDTH];
   assign d3 = head[2*WIDTH +: WIDTH];
   assign d4 = head[3*WIDTH +: WIDTH];

   // A producer that was stalled last cycle must present the same in_sel now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q  <= 1'b0;
         sel_q    <= 2'd0;
         err_drop <= 1'b0;
      end else begin
         stall_q <= in_valid & ~in_ready;
         sel_q   <= in_sel;
         if (stall_q && in_valid && (in_sel != sel_q)) err_drop <= 1'b1;
      end
   end

endmodule
